// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cpu_sequencer
// Description : Multi-cycle control sequencer for a small 8-bit CPU. Fetches
//               one- or two-byte instructions from instruction memory, decodes
//               them, and issues single-cycle datapath strobes and a
//               data-memory handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   1  clock, all state updates on the rising edge
//   reset       in   1  asynchronous active-high reset
//   run         in   1  start request, sampled only in IDLE
//   step        in   1  single-step request (only with SINGLE_STEP_EN)
//   imem_req    out  1  instruction-memory read request
//   imem_ready  in   1  imem_data valid
//   imem_data   in   8  instruction / immediate byte
//   pc          out  8  program counter, also the imem address
//   ir          out  8  latched instruction
//   opcode      out  4  ir[7:4]
//   rd          out  2  ir[3:2]
//   rs          out  2  ir[1:0]
//   imm         out  8  latched immediate byte
//   dmem_req    out  1  data-memory request
//   dmem_we     out  1  data-memory write enable
//   dmem_ready  in   1  data-memory access complete
//   alu_en      out  1  ALU strobe, one cycle
//   reg_write   out  1  register-file write strobe, one cycle
//   zero_flag   in   1  datapath zero flag, used by BZ
//   halted      out  1  high while in HALT
// ----------------------------------------------------------------------------
// Build option
//   SINGLE_STEP_EN : adds the step port; after every instruction the sequencer
//                    parks in IDLE and runs exactly one instruction per step
//                    pulse.
// ============================================================================
module cpu_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
`ifdef SINGLE_STEP_EN
    input  logic       step,
`endif
    output logic       imem_req,
    input  logic       imem_ready,
    input  logic [7:0] imem_data,
    output logic [7:0] pc,
    output logic [7:0] ir,
    output logic [3:0] opcode,
    output logic [1:0] rd,
    output logic [1:0] rs,
    output logic [7:0] imm,
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ready,
    output logic       alu_en,
    output logic       reg_write,
    input  logic       zero_flag,
    output logic       halted
);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_FETCH     = 3'd1;
    localparam logic [2:0] c_ST_DECODE    = 3'd2;
    localparam logic [2:0] c_ST_FETCH_IMM = 3'd3;
    localparam logic [2:0] c_ST_EXEC      = 3'd4;
    localparam logic [2:0] c_ST_MEM       = 3'd5;
    localparam logic [2:0] c_ST_WB        = 3'd6;
    localparam logic [2:0] c_ST_HALT      = 3'd7;

    localparam logic [3:0] c_OP_LD  = 4'h4;
    localparam logic [3:0] c_OP_ST  = 4'h5;
    localparam logic [3:0] c_OP_LDI = 4'h6;
    localparam logic [3:0] c_OP_JMP = 4'h7;
    localparam logic [3:0] c_OP_BZ  = 4'h8;
    localparam logic [3:0] c_OP_HLT = 4'hF;

    // Where an instruction goes when it is finished: straight to the next
    // fetch, or back to IDLE to wait for the next step pulse.
`ifdef SINGLE_STEP_EN
    localparam logic [2:0] c_ST_NEXT = c_ST_IDLE;
`else
    localparam logic [2:0] c_ST_NEXT = c_ST_FETCH;
`endif

    logic [2:0] r_state;
    logic [7:0] r_pc;
    logic [7:0] r_ir;
    logic [7:0] r_imm;
    logic       r_imem_req;
    logic       r_dmem_req;
    logic       r_dmem_we;
    logic       r_alu_en;
    logic       r_reg_write;
    logic       r_halted;

    logic [2:0] w_state_nxt;
    logic [7:0] w_pc_nxt;
    logic [7:0] w_ir_nxt;
    logic [7:0] w_imm_nxt;
    logic [3:0] w_op;
    logic [3:0] w_op_nxt;
    logic       w_go;
    logic       w_is_mem_nxt;

`ifdef SINGLE_STEP_EN
    // r_armed: the first run has been taken; from then on IDLE waits for step.
    // r_step_pend: a step rising edge seen but not yet consumed, so a pulse
    // arriving mid-instruction is not lost and a long pulse counts once.
    logic r_armed;
    logic r_step_q;
    logic r_step_pend;
    logic w_step_take;

    assign w_step_take = (r_state == c_ST_IDLE) && r_armed && r_step_pend;
    assign w_go        = r_armed ? r_step_pend : run;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_armed     <= 1'b0;
            r_step_q    <= 1'b0;
            r_step_pend <= 1'b0;
        end else begin
            r_step_q    <= step;
            r_step_pend <= (r_step_pend && !w_step_take) || (step && !r_step_q);
            if ((r_state == c_ST_IDLE) && w_go) begin
                r_armed <= 1'b1;
            end
        end
    end
`else
    assign w_go = run;
`endif

    assign w_op     = r_ir[7:4];
    assign w_op_nxt = w_ir_nxt[7:4];

    // Next-state and datapath-register updates.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_imm_nxt   = r_imm;
        case (r_state)
            c_ST_IDLE: begin
                if (w_go) begin
                    w_state_nxt = c_ST_FETCH;
                end
            end
            c_ST_FETCH: begin
                if (imem_ready) begin
                    w_ir_nxt    = imem_data;
                    w_pc_nxt    = r_pc + 8'd1;
                    w_state_nxt = c_ST_DECODE;
                end
            end
            c_ST_DECODE: begin
                if ((w_op == c_OP_LDI) || (w_op == c_OP_JMP) || (w_op == c_OP_BZ)) begin
                    w_state_nxt = c_ST_FETCH_IMM;
                end else begin
                    w_state_nxt = c_ST_EXEC;
                end
            end
            c_ST_FETCH_IMM: begin
                if (imem_ready) begin
                    w_imm_nxt   = imem_data;
                    w_pc_nxt    = r_pc + 8'd1;
                    w_state_nxt = c_ST_EXEC;
                end
            end
            c_ST_EXEC: begin
                case (w_op)
                    4'h0, 4'h1, 4'h2, 4'h3: w_state_nxt = c_ST_WB;
                    c_OP_LD, c_OP_ST:       w_state_nxt = c_ST_MEM;
                    c_OP_LDI:               w_state_nxt = c_ST_WB;
                    c_OP_JMP: begin
                        w_pc_nxt    = r_imm;
                        w_state_nxt = c_ST_NEXT;
                    end
                    c_OP_BZ: begin
                        if (zero_flag) begin
                            w_pc_nxt = r_imm;
                        end
                        w_state_nxt = c_ST_NEXT;
                    end
                    c_OP_HLT:               w_state_nxt = c_ST_HALT;
                    default:                w_state_nxt = c_ST_NEXT;
                endcase
            end
            c_ST_MEM: begin
                if (dmem_ready) begin
                    w_state_nxt = (w_op == c_OP_LD) ? c_ST_WB : c_ST_NEXT;
                end
            end
            c_ST_WB: begin
                w_state_nxt = c_ST_NEXT;
            end
            c_ST_HALT: begin
                w_state_nxt = c_ST_HALT;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // The data request is raised on entry to EXEC and held through MEM.
    assign w_is_mem_nxt = (w_op_nxt == c_OP_LD) || (w_op_nxt == c_OP_ST);

    // Strobes are registered from the next state so each one is high exactly
    // for the cycles the sequencer spends in the owning state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_pc        <= 8'h00;
            r_ir        <= 8'h00;
            r_imm       <= 8'h00;
            r_imem_req  <= 1'b0;
            r_dmem_req  <= 1'b0;
            r_dmem_we   <= 1'b0;
            r_alu_en    <= 1'b0;
            r_reg_write <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_ir        <= w_ir_nxt;
            r_imm       <= w_imm_nxt;
            r_imem_req  <= (w_state_nxt == c_ST_FETCH) || (w_state_nxt == c_ST_FETCH_IMM);
            r_dmem_req  <= ((w_state_nxt == c_ST_EXEC) || (w_state_nxt == c_ST_MEM)) && w_is_mem_nxt;
            r_dmem_we   <= ((w_state_nxt == c_ST_EXEC) || (w_state_nxt == c_ST_MEM)) &&
                           (w_op_nxt == c_OP_ST);
            r_alu_en    <= (w_state_nxt == c_ST_EXEC) && (w_op_nxt[3:2] == 2'b00);
            r_reg_write <= (w_state_nxt == c_ST_WB);
            r_halted    <= (w_state_nxt == c_ST_HALT);
        end
    end

    assign imem_req  = r_imem_req;
    assign pc        = r_pc;
    assign ir        = r_ir;
    assign opcode    = r_ir[7:4];
    assign rd        = r_ir[3:2];
    assign rs        = r_ir[1:0];
    assign imm       = r_imm;
    assign dmem_req  = r_dmem_req;
    assign dmem_we   = r_dmem_we;
    assign alu_en    = r_alu_en;
    assign reg_write = r_reg_write;
    assign halted    = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_cpu_sequencer
// Description : Self-checking bench for cpu_sequencer. An instruction-level
//               reference model fills per-kind expected-event queues; a
//               monitor turns DUT strobe activity into events and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic       imem_req;
    logic       imem_ready;
    logic [7:0] imem_data;
    logic [7:0] pc;
    logic [7:0] ir;
    logic [3:0] opcode;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] imm;
    logic       dmem_req;
    logic       dmem_we;
    logic       dmem_ready;
    logic       alu_en;
    logic       reg_write;
    logic       zero_flag;
    logic       halted;
`ifdef SINGLE_STEP_EN
    logic       step = 1'b0;
`endif

    always #5 clk = ~clk;

    cpu_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
`ifdef SINGLE_STEP_EN
        .step       (step),
`endif
        .imem_req   (imem_req),
        .imem_ready (imem_ready),
        .imem_data  (imem_data),
        .pc         (pc),
        .ir         (ir),
        .opcode     (opcode),
        .rd         (rd),
        .rs         (rs),
        .imm        (imm),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ready (dmem_ready),
        .alu_en     (alu_en),
        .reg_write  (reg_write),
        .zero_flag  (zero_flag),
        .halted     (halted)
    );

    typedef struct {
        int a;
        int b;
        int cyc;
    } ev_t;

    // Expected events per kind: imem read (a=addr, b=cycles req high),
    // dmem access (a=we, b=cycles req high), alu (a=ir), wb (a=ir, b=imm),
    // halt (a=pc).
    ev_t q_imem[$];
    ev_t q_dmem[$];
    ev_t q_alu[$];
    ev_t q_wb[$];
    ev_t q_halt[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] pmem [256];
    int         imem_wait [512];
    int         dmem_wait [512];
    bit         zf;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk(input int a, input int b, input int c);
        ev_t e;
        e.a = a;
        e.b = b;
        e.cyc = c;
        return e;
    endfunction

    task automatic check_ev(input int kind, input int a, input int b, input int c);
        ev_t   e;
        bit    have;
        string nm;
        have = 0;
        case (kind)
            0: begin nm = "imem"; if (q_imem.size() > 0) begin e = q_imem.pop_front(); have = 1; end end
            1: begin nm = "dmem"; if (q_dmem.size() > 0) begin e = q_dmem.pop_front(); have = 1; end end
            2: begin nm = "alu";  if (q_alu.size()  > 0) begin e = q_alu.pop_front();  have = 1; end end
            3: begin nm = "wb";   if (q_wb.size()   > 0) begin e = q_wb.pop_front();   have = 1; end end
            default: begin nm = "halt"; if (q_halt.size() > 0) begin e = q_halt.pop_front(); have = 1; end end
        endcase
        checks++;
        if (!have) begin
            failures++;
            $display("FAIL %s_event unexpected: got a=%0h b=%0h cyc=%0d, required none", nm, a, b, c);
        end else if (e.a != a || e.b != b || e.cyc != c) begin
            failures++;
            $display("FAIL %s_event: got a=%0h b=%0h cyc=%0d, required a=%0h b=%0h cyc=%0d",
                     nm, a, b, c, e.a, e.b, e.cyc);
        end
    endtask

    // Instruction-level reference: walks the program, accumulating the cycle
    // count each instruction class needs, and records the events it causes.
    task automatic model_run(input int t0, input int kmax, output int t_end,
                             output bit halts, output int ii);
        int         pcm, immm, t, di, w;
        logic [7:0] irm;
        int         op;
        pcm = 0; immm = 0; t = t0; ii = 0; di = 0; halts = 0;
        for (int k = 0; k < kmax && !halts; k++) begin
            w = imem_wait[ii]; ii++;
            q_imem.push_back(mk(pcm, w + 1, t));
            irm = pmem[pcm];
            pcm = (pcm + 1) % 256;
            t = t + w + 2;                  // fetch plus decode
            op = int'(irm[7:4]);
            if (op == 6 || op == 7 || op == 8) begin
                w = imem_wait[ii]; ii++;
                q_imem.push_back(mk(pcm, w + 1, t));
                immm = int'(pmem[pcm]);
                pcm = (pcm + 1) % 256;
                t = t + w + 1;
            end
            // t is now the execute cycle
            if (op <= 3) begin
                q_alu.push_back(mk(int'(irm), 0, t));
                q_wb.push_back(mk(int'(irm), immm, t + 1));
                t = t + 2;
            end else if (op == 4) begin
                w = dmem_wait[di]; di++;
                q_dmem.push_back(mk(0, w + 2, t));
                t = t + w + 2;
                q_wb.push_back(mk(int'(irm), immm, t));
                t = t + 1;
            end else if (op == 5) begin
                w = dmem_wait[di]; di++;
                q_dmem.push_back(mk(1, w + 2, t));
                t = t + w + 2;
            end else if (op == 6) begin
                q_wb.push_back(mk(int'(irm), immm, t + 1));
                t = t + 2;
            end else if (op == 7) begin
                pcm = immm;
                t = t + 1;
            end else if (op == 8) begin
                if (zf) pcm = immm;
                t = t + 1;
            end else if (op == 15) begin
                halts = 1;
                t = t + 1;
                q_halt.push_back(mk(pcm, 0, t));
            end else begin
                t = t + 1;
            end
        end
        t_end = t;
    endtask

    // Instruction memory: answers after imem_wait[k] idle cycles; drives
    // noise on imem_ready while no request is up.
    initial begin : imem_model
        int  i_idx, i_cnt;
        bit  i_done;
        i_idx = 0; i_cnt = 0; i_done = 0;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                i_idx = 0; i_cnt = 0; i_done = 0;
                imem_ready = 1'b0;
            end else if (imem_req && !i_done) begin
                if (i_cnt == imem_wait[i_idx]) begin
                    imem_ready = 1'b1;
                    imem_data  = pmem[pc];
                    i_done     = 1;
                end else begin
                    imem_ready = 1'b0;
                    imem_data  = 8'($urandom);
                end
                i_cnt++;
            end else begin
                if (i_done) i_idx++;
                i_done = 0; i_cnt = 0;
                imem_ready = 1'($urandom_range(0, 1));
                imem_data  = 8'($urandom);
            end
        end
    end

    // Data memory: the first request cycle is execute, where ready is noise;
    // after that ready comes after dmem_wait[k] further cycles.
    initial begin : dmem_model
        int  d_idx, d_cnt;
        bit  d_done;
        d_idx = 0; d_cnt = 0; d_done = 0;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                d_idx = 0; d_cnt = 0; d_done = 0;
                dmem_ready = 1'b0;
            end else if (dmem_req && !d_done) begin
                if (d_cnt == 0) begin
                    dmem_ready = 1'($urandom_range(0, 1));
                end else if (d_cnt == dmem_wait[d_idx] + 1) begin
                    dmem_ready = 1'b1;
                    d_done     = 1;
                end else begin
                    dmem_ready = 1'b0;
                end
                d_cnt++;
            end else begin
                if (d_done) d_idx++;
                d_done = 0; d_cnt = 0;
                dmem_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: converts strobe activity into events and scores them.
    initial begin : monitor
        bit i_act, d_act, d_we0, d_unstable, h_prev;
        int i_start, i_pc, i_len, d_start, d_len;
        i_act = 0; d_act = 0; h_prev = 0;
        i_start = 0; i_pc = 0; i_len = 0; d_start = 0; d_len = 0; d_we0 = 0; d_unstable = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                i_act = 0; d_act = 0; h_prev = 0;
            end else begin
                if (imem_req) begin
                    if (!i_act) begin i_act = 1; i_start = cyc; i_pc = int'(pc); i_len = 0; end
                    i_len++;
                end else if (i_act) begin
                    i_act = 0;
                    check_ev(0, i_pc, i_len, i_start);
                end
                if (dmem_req) begin
                    if (!d_act) begin
                        d_act = 1; d_start = cyc; d_we0 = dmem_we; d_unstable = 0; d_len = 0;
                    end else if (dmem_we != d_we0) begin
                        d_unstable = 1;
                    end
                    d_len++;
                end else if (d_act) begin
                    d_act = 0;
                    check_ev(1, d_unstable ? 2 : int'(d_we0), d_len, d_start);
                end
                if (alu_en)    check_ev(2, int'({opcode, rd, rs}), 0, cyc);
                if (reg_write) check_ev(3, int'({opcode, rd, rs}), int'(imm), cyc);
                if (halted && !h_prev) check_ev(4, int'(pc), 0, cyc);
                h_prev = halted;
            end
        end
    end

    task automatic check_reset_outputs(input string nm);
        checks++;
        if (imem_req !== 1'b0 || dmem_req !== 1'b0 || dmem_we !== 1'b0 || alu_en !== 1'b0 ||
            reg_write !== 1'b0 || halted !== 1'b0 || pc !== 8'h00 || ir !== 8'h00 || imm !== 8'h00) begin
            failures++;
            $display("FAIL %s: got imem_req=%b dmem_req=%b dmem_we=%b alu_en=%b reg_write=%b halted=%b pc=%h ir=%h imm=%h, required all zero",
                     nm, imem_req, dmem_req, dmem_we, alu_en, reg_write, halted, pc, ir, imm);
        end
    endtask

    // Runs the program in pmem from reset for at most kmax instructions. A
    // halting program is watched for 20 cycles in HALT; otherwise reset is
    // asserted while the next fetch is still waiting on memory.
    task automatic run_prog(input string nm, input int kmax, input bit zero_wait,
                            input bit zf_in, input int dw0);
        int t0, t_end, ii, hcnt, left;
        bit halts, done;
        for (int i = 0; i < 512; i++) begin
            imem_wait[i] = zero_wait ? 0 : int'($urandom_range(0, 2));
            dmem_wait[i] = zero_wait ? 0 : int'($urandom_range(0, 3));
        end
        if (dw0 >= 0) dmem_wait[0] = dw0;
        zf = zf_in;
        zero_flag = zf_in;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run = 1'b1;
        t0 = cyc + 1;
        model_run(t0, kmax, t_end, halts, ii);
        if (!halts) imem_wait[ii] = 3;
        hcnt = 0;
        done = 0;
        for (int g = 0; g < 5000 && !done; g++) begin
            @(negedge clk);
            #1;
            run = 1'($urandom_range(0, 1));
            if (halts && cyc >= t_end && cyc < t_end + 20) hcnt += int'(halted);
            if (cyc == t_end + (halts ? 20 : 0)) done = 1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s_timeout: got cyc=%0d, required end at cyc=%0d", nm, cyc, t_end);
        end
        if (halts) begin
            checks++;
            if (hcnt != 20) begin
                failures++;
                $display("FAIL %s_halt_hold: got halted for %0d cycles, required 20", nm, hcnt);
            end
        end
        reset = 1'b1;
        run = 1'b0;
        #1;
        check_reset_outputs({nm, "_async_reset"});
        left = q_imem.size() + q_dmem.size() + q_alu.size() + q_wb.size() + q_halt.size();
        checks++;
        if (left != 0) begin
            failures++;
            $display("FAIL %s_missing_events: got %0d expected events never seen, required 0", nm, left);
        end
        q_imem.delete(); q_dmem.delete(); q_alu.delete(); q_wb.delete(); q_halt.delete();
        @(negedge clk);
    endtask

    task automatic fill_halt();
        for (int i = 0; i < 256; i++) pmem[i] = 8'hF0;
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        reset = 1'b1;
        run = 1'b0;
        zero_flag = 1'b0;
        imem_ready = 1'b0;
        imem_data = 8'h00;
        dmem_ready = 1'b0;
        fill_halt();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");

        // ADD with zero wait, then halt
        fill_halt();
        pmem[0] = 8'h00;
        run_prog("add", 10, 1, 0, -1);

        // LDI r1, 0x5A
        fill_halt();
        pmem[0] = 8'h64; pmem[1] = 8'h5A; pmem[2] = 8'hF0;
        run_prog("ldi", 10, 1, 0, -1);

        // BZ 0x10 taken and not taken
        fill_halt();
        pmem[0] = 8'h80; pmem[1] = 8'h10; pmem[2] = 8'h90; pmem[3] = 8'hF0; pmem[16] = 8'hF0;
        run_prog("bz_taken", 10, 1, 1, -1);
        run_prog("bz_not_taken", 10, 1, 0, -1);

        // ST with ready three cycles after the request rises
        fill_halt();
        pmem[0] = 8'h5B; pmem[1] = 8'hF0;
        run_prog("st_wait", 10, 1, 0, 2);

        // JMP fetched at 0xFF reads its immediate from 0x00
        fill_halt();
        pmem[0] = 8'h70; pmem[1] = 8'hFF; pmem[8'hFF] = 8'h70; pmem[8'h70] = 8'hF0;
        pmem[2] = 8'h00;
        run_prog("jmp_wrap", 10, 1, 0, -1);

        // Random programs with random memory latencies
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 256; i++) pmem[i] = 8'($urandom);
            run_prog("random", 30, 0, 1'($urandom_range(0, 1)), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit; reset is asynchronous and active-high.
REQ-003 SHALL have port run, input, 1 bit, the start request sampled in IDLE.
REQ-004 SHALL have port imem_req, output, 1 bit, the instruction-memory read request.
REQ-005 SHALL have port imem_ready, input, 1 bit; it marks imem_data valid.
REQ-006 SHALL have port imem_data, input, 8 bits, the instruction or immediate byte.
REQ-007 SHALL have port pc, output, 8 bits, the program counter and imem address.
REQ-008 SHALL have port ir, output, 8 bits, the latched instruction.
REQ-009 SHALL have ports opcode (output, 4 bits, ir[7:4]), rd (output, 2 bits, ir[3:2]) and rs (output, 2 bits, ir[1:0]).
REQ-010 SHALL have port imm, output, 8 bits, the latched second byte.
REQ-011 SHALL have ports dmem_req (output, 1), dmem_we (output, 1) and dmem_ready (input, 1), the data-memory handshake.
REQ-012 SHALL have ports alu_en (output, 1) and reg_write (output, 1), single-cycle datapath strobes.
REQ-013 SHALL have port zero_flag, input, 1 bit, the datapath zero flag.
REQ-014 SHALL have port halted, output, 1 bit; it is high in HALT.

Function
REQ-015 SHALL implement states IDLE, FETCH, DECODE, FETCH_IMM, EXEC, MEM, WB and HALT.
REQ-016 SHALL transition IDLE->FETCH on the first edge with run=1; run is ignored in all other states.
REQ-017 SHALL hold imem_req=1 throughout FETCH; when imem_ready=1: ir<=imem_data, pc<=pc+1, and go to DECODE. A zero-wait fetch takes 1 cycle.
REQ-018 SHALL go from DECODE to FETCH_IMM for two-byte opcodes LDI(0110), JMP(0111) and BZ(1000), and to EXEC otherwise.
REQ-019 SHALL in FETCH_IMM hold imem_req=1; when imem_ready=1: imm<=imem_data, pc<=pc+1, and go to EXEC.
REQ-020 SHALL in EXEC handle the opcode as follows:
- ADD/SUB/AND/OR (0000-0011): alu_en=1 for one cycle, then WB.
- LD (0100): dmem_req=1, dmem_we=0, then MEM.
- ST (0101): dmem_req=1, dmem_we=1, then MEM.
- LDI: go to WB.
- JMP: pc<=imm, then FETCH.
- BZ: pc<=imm if zero_flag=1, else pc unchanged; then FETCH.
- HLT (1111): go to HALT.
- Any other opcode: NOP, go to FETCH.
REQ-021 SHALL hold dmem_req and dmem_we stable in MEM until dmem_ready=1; then go to WB for LD and to FETCH for ST.
REQ-022 SHALL assert reg_write for exactly one cycle in WB, then go to FETCH.
REQ-023 SHALL give zero-wait latency in cycles, fetch edge to next FETCH entry: ALU 4, LD 5, ST 4, LDI 5, JMP/BZ 4, NOP 3.
REQ-024 SHALL wrap pc modulo 256 (0xFF+1=0x00), including the immediate fetch.
REQ-025 SHALL deassert alu_en, reg_write, dmem_req and imem_req in every state other than those named above.
REQ-026 SHALL remain in HALT, with all strobes 0, until reset.
REQ-027 SHALL ignore imem_ready outside FETCH/FETCH_IMM and dmem_ready outside MEM.

Reset
REQ-028 SHALL on reset, immediately and asynchronously, set: state=IDLE, pc=0x00, ir=0x00, imm=0x00, and imem_req, dmem_req, dmem_we, alu_en, reg_write and halted to 0.
REQ-029 SHALL abandon any outstanding memory handshake when reset is asserted mid-wait; no write strobe is issued after reset.

Configuration
REQ-030 SHALL, with SINGLE_STEP_EN defined:
- add input port step (1 bit);
- on each return to FETCH, go instead to IDLE and wait for step=1 (run is ignored);
- exactly one instruction executes per step pulse.
REQ-031 SHALL, without SINGLE_STEP_EN, have no step port and run instructions back-to-back.

Verification
REQ-032 SHALL cover: reset, run=1, imem returns 0x00 (ADD) with zero wait -> alu_en high on cycle 3, reg_write on cycle 4, pc=0x01, FETCH re-entered on cycle 5.
REQ-033 SHALL cover: LDI with bytes 0x64, 0x5A -> imm=0x5A, rd=01, one reg_write pulse, pc=0x02.
REQ-034 SHALL cover: BZ 0x80, 0x10 with zero_flag=1 -> pc=0x10; with zero_flag=0 -> pc=0x02.
REQ-035 SHALL cover: ST with dmem_ready delayed 3 cycles -> dmem_req=1 and dmem_we=1 held for 4 cycles, no reg_write.
REQ-036 SHALL cover: pc=0xFF, fetch a JMP -> immediate read at pc=0x00, pc=imm afterwards.
REQ-037 SHALL cover: reset asserted mid-FETCH wait -> imem_req low before the next edge, pc=0x00; HLT 0xF0 -> halted=1 held for 20 cycles.
